// File: rtl/mem_responder.sv
// Multicycle memory responder: one outstanding word request, fixed wait states, registered response.
// Optional byte-lane write strobes are enabled with `define MEMRESP_BYTE_STROBE_EN.
module mem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        reqWrite,
    input  logic [31:0] reqAddr,
    input  logic [31:0] reqWData,
`ifdef MEMRESP_BYTE_STROBE_EN
    input  logic [3:0]  reqByteEn,
`endif
    output logic        respValid,
    input  logic        respReady,
    output logic [31:0] respRData,
    output logic        respError,
    output logic        busy
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic        write_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [31:0] rdata_reg;
    logic        error_reg;
    logic        latch_req;
    logic        clr_resp;
    logic        access;
    logic        addr_error;
    logic        mem_we;
    logic        mem_re;
    logic [3:0]  lane_en;
    logic [3:0]  lane_we;
    logic [ADDR_WIDTH-1:0] word_idx;

    logic [31:0] mem [0:DEPTH-1];

`ifdef MEMRESP_BYTE_STROBE_EN
    logic [3:0] be_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            be_reg <= 4'h0;
        end else if (latch_req) begin
            be_reg <= reqByteEn;
        end
    end

    assign lane_en = be_reg;
`else
    assign lane_en = 4'hF;
`endif

    // Misaligned or beyond-the-array addresses never touch the memory.
    assign addr_error = (addr_reg[1:0] != 2'b00) || (addr_reg[31:ADDR_WIDTH+2] != '0);
    assign word_idx   = addr_reg[ADDR_WIDTH+1:2];
    assign access     = (state_reg == S_WAIT) && (cnt_reg == 4'd0);
    assign mem_we     = access && write_reg && !addr_error && !reset;
    assign mem_re     = access && !write_reg && !addr_error;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_we[gi] = mem_we && lane_en[gi];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        latch_req  = 1'b0;
        clr_resp   = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (reqValid) begin
                    latch_req  = 1'b1;
                    cnt_next   = 4'(WAIT_CYCLES);
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_reg != 4'd0) begin
                    cnt_next = cnt_reg - 4'd1;
                end else begin
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                if (respReady) begin
                    state_next = S_IDLE;
                    clr_resp   = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= S_IDLE;
            cnt_reg   <= 4'd0;
            write_reg <= 1'b0;
            addr_reg  <= 32'd0;
            wdata_reg <= 32'd0;
            rdata_reg <= 32'd0;
            error_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (latch_req) begin
                write_reg <= reqWrite;
                addr_reg  <= reqAddr;
                wdata_reg <= reqWData;
            end
            if (access) begin
                error_reg <= addr_error;
                rdata_reg <= mem_re ? mem[word_idx] : 32'd0;
            end else if (clr_resp) begin
                error_reg <= 1'b0;
                rdata_reg <= 32'd0;
            end
        end
    end

    // Array has no reset so it maps onto block RAM with per-byte write enables.
    always_ff @(posedge clock) begin
        for (int b = 0; b < 4; b++) begin
            if (lane_we[b]) begin
                mem[word_idx][8*b +: 8] <= wdata_reg[8*b +: 8];
            end
        end
    end

    assign reqReady  = (state_reg == S_IDLE);
    assign respValid = (state_reg == S_RESP);
    assign busy      = (state_reg != S_IDLE);
    assign respRData = rdata_reg;
    assign respError = error_reg;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus randomized traffic against a word-array model.
module tb_mem_responder;

    localparam int AW = 10;
    localparam int W  = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        reqValid = 1'b0;
    logic        reqWrite = 1'b0;
    logic [31:0] reqAddr = 32'd0;
    logic [31:0] reqWData = 32'd0;
    logic [3:0]  reqByteEn = 4'hF;
    logic        respReady = 1'b0;
    logic        reqReady;
    logic        respValid;
    logic [31:0] respRData;
    logic        respError;
    logic        busy;

    int errors = 0;
    int checks = 0;

    logic [31:0] model [0:(1<<AW)-1];

    mem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(W)) dut (
        .clock(clock),
        .reset(reset),
        .reqValid(reqValid),
        .reqReady(reqReady),
        .reqWrite(reqWrite),
        .reqAddr(reqAddr),
        .reqWData(reqWData),
`ifdef MEMRESP_BYTE_STROBE_EN
        .reqByteEn(reqByteEn),
`endif
        .respValid(respValid),
        .respReady(respReady),
        .respRData(respRData),
        .respError(respError),
        .busy(busy)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // A legal byte address is word aligned and lies inside the 4*depth byte window.
    function automatic bit addr_err(input logic [31:0] a);
        return (a % 4 != 0) || (a >= 32'(4 << AW));
    endfunction

    task automatic idle_checks(input string tag);
        chk({tag, "/reqReady"},  32'(reqReady),  32'd1);
        chk({tag, "/respValid"}, 32'(respValid), 32'd0);
        chk({tag, "/busy"},      32'(busy),      32'd0);
        chk({tag, "/rdata"},     respRData,      32'd0);
        chk({tag, "/error"},     32'(respError), 32'd0);
    endtask

    task automatic txn(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be, input int stall, input string tag);
        logic [31:0] exp_rd;
        logic [3:0]  eff_be;
        bit          exp_err;
        int          edges;
        exp_err = addr_err(a);
        exp_rd  = 32'd0;
`ifdef MEMRESP_BYTE_STROBE_EN
        eff_be = be;
`else
        eff_be = 4'hF;
`endif
        if (!exp_err) begin
            if (wr) begin
                for (int b = 0; b < 4; b++)
                    if (eff_be[b]) model[a / 4][8*b +: 8] = wd[8*b +: 8];
            end else begin
                exp_rd = model[a / 4];
            end
        end

        @(negedge clock);
        chk({tag, "/reqReady_idle"}, 32'(reqReady), 32'd1);
        reqValid  = 1'b1;
        reqWrite  = wr;
        reqAddr   = a;
        reqWData  = wd;
        reqByteEn = be;
        respReady = 1'b0;
        @(posedge clock);
        @(negedge clock);
        chk({tag, "/busy_wait"}, 32'(busy), 32'd1);
        // Request-channel activity while busy must be ignored.
        reqValid  = 1'($urandom_range(0, 1));
        reqWrite  = 1'($urandom_range(0, 1));
        reqAddr   = $urandom;
        reqWData  = $urandom;
        edges = 0;
        while (!respValid && edges < 40) begin
            respReady = 1'($urandom_range(0, 1));
            @(posedge clock);
            edges++;
            @(negedge clock);
        end
        respReady = 1'b0;
        chk({tag, "/latency"}, 32'(edges), 32'(W + 1));
        chk({tag, "/rdata"},   respRData,  exp_rd);
        chk({tag, "/error"},   32'(respError), 32'(exp_err));
        for (int i = 0; i < stall; i++) begin
            @(posedge clock);
            @(negedge clock);
            chk({tag, "/stall_valid"}, 32'(respValid), 32'd1);
            chk({tag, "/stall_rdata"}, respRData, exp_rd);
            chk({tag, "/stall_ready"}, 32'(reqReady), 32'd0);
        end
        reqValid  = 1'b0;
        respReady = 1'b1;
        @(posedge clock);
        @(negedge clock);
        respReady = 1'b0;
        idle_checks({tag, "/after"});
        $display("txn %s wr=%0d addr=%h wd=%h be=%h exp_rd=%h exp_err=%0d lat=%0d stall=%0d",
                 tag, wr, a, wd, be, exp_rd, exp_err, edges, stall);
    endtask

    initial begin
        logic [31:0] a;
        int          sel;
        int          idx;

        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            idle_checks("reset_idle");
        end

        for (int i = 0; i < 16; i++) txn(1'b1, 32'(i * 4), $urandom, 4'hF, 0, "preload");
        txn(1'b1, 32'(((1 << AW) - 1) * 4), $urandom, 4'hF, 0, "preload_top");

        txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, "wr_0x10");
        txn(1'b0, 32'h10, 32'h0, 4'hF, 0, "rd_0x10");
        chk("rd_0x10_const", model[4], 32'hDEADBEEF);
        txn(1'b0, 32'h13, 32'h0, 4'hF, 0, "rd_misaligned");
        txn(1'b1, 32'h1000, 32'hCAFEF00D, 4'hF, 0, "wr_out_of_range");
        txn(1'b0, 32'h0, 32'h0, 4'hF, 0, "rd_0x0");
        txn(1'b0, 32'h10, 32'h0, 4'hF, 5, "backpressure");
        txn(1'b0, 32'(((1 << AW) - 1) * 4), 32'h0, 4'hF, 0, "rd_top");

        // Reset during the first wait cycle of a write drops it entirely.
        @(negedge clock);
        reqValid = 1'b1;
        reqWrite = 1'b1;
        reqAddr  = 32'h20;
        reqWData = 32'h12345678;
        @(posedge clock);
        @(negedge clock);
        chk("rst_mid/busy", 32'(busy), 32'd1);
        reqValid = 1'b0;
        reset    = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        idle_checks("rst_mid");
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            chk("rst_mid/no_resp", 32'(respValid), 32'd0);
        end
        $display("txn rst_mid write 0x20 dropped by reset");
        txn(1'b0, 32'h20, 32'h0, 4'hF, 0, "rd_after_rst");

`ifdef MEMRESP_BYTE_STROBE_EN
        txn(1'b1, 32'h4, 32'hAABBCCDD, 4'hF, 0, "be_full");
        txn(1'b1, 32'h4, 32'h11223344, 4'b0101, 0, "be_0101");
        txn(1'b0, 32'h4, 32'h0, 4'hF, 0, "be_rd");
        chk("be_rd_const", model[1], 32'hAA22CC44);
        txn(1'b1, 32'h4, 32'h55667788, 4'b0000, 0, "be_none");
        txn(1'b0, 32'h4, 32'h0, 4'b0000, 0, "be_rd_none");
`endif

        for (int n = 0; n < 60; n++) begin
            sel = $urandom_range(0, 7);
            idx = ($urandom_range(0, 9) == 0) ? ((1 << AW) - 1) : $urandom_range(0, 15);
            if (sel == 0)      a = 32'(idx * 4) | 32'($urandom_range(1, 3));
            else if (sel == 1) a = 32'(4 << AW) + ($urandom & 32'h7FFF_FFFC);
            else               a = 32'(idx * 4);
            txn(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                $urandom_range(0, 3), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
